// File: rtl/bcd_to_signed_bin_if.sv
// Handshake and data bundle between the operator-entry side and the BCD-to-binary converter.
interface bcd_to_signed_bin_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                    start;
  logic                    negative;
  logic [4*DIGITS-1:0]     bcd_in;
  logic                    busy;
  logic                    done;
  logic signed [BIN_W:0]   result;
  logic                    err;
  logic                    ovf;

  modport master (
    output start, negative, bcd_in,
    input  busy, done, result, err, ovf
  );

  modport slave (
    input  start, negative, bcd_in,
    output busy, done, result, err, ovf
  );
endinterface

// File: rtl/bcd_to_signed_bin.sv
// Sign + packed BCD to two's-complement converter using reverse double-dabble (one bit per clock).
// Optional 8-bit clamp of the signed result is enabled by defining SATURATE_8BIT_EN.
module bcd_to_signed_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_to_signed_bin_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int RES_W = BIN_W + 1;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SHIFT, S_NEGATE, S_DONE
  } state_t;

  state_t                    state_q;
  logic [BCD_W-1:0]          bcd_q;
  logic                      neg_q;
  logic [SR_W-1:0]           sr_q;
  logic [SR_W-1:0]           sr_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic signed [RES_W-1:0]   result_q;
  logic signed [RES_W-1:0]   result_d;
`ifdef SATURATE_8BIT_EN
  logic                      ovf_q;
  logic                      ovf_d;
`endif

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Shift right, then pull each BCD digit that reached 8+ back down by 3 (inverse of add-3).
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    s = sr >> 1;
    for (int i = 0; i < DIGITS; i++)
      if (s[BIN_W+4*i +: 4] >= 4'd8)
        s[BIN_W+4*i +: 4] = s[BIN_W+4*i +: 4] - 4'd3;
    return s;
  endfunction

  // Zero magnitude negates to zero, so no negative zero can appear.
  function automatic logic signed [RES_W-1:0] apply_sign(input logic [BIN_W-1:0] mag,
                                                         input logic neg);
    logic signed [RES_W-1:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

`ifdef SATURATE_8BIT_EN
  function automatic logic signed [RES_W-1:0] sat8(input logic signed [RES_W-1:0] v,
                                                   output logic clamped);
    logic signed [RES_W-1:0] hi;
    logic signed [RES_W-1:0] lo;
    hi = RES_W'(127);
    lo = RES_W'(-128);
    clamped = 1'b0;
    if (v > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return v;
  endfunction
`endif

  always_comb begin
    sr_d     = dabble_step(sr_q);
    result_d = apply_sign(sr_q[BIN_W-1:0], neg_q);
`ifdef SATURATE_8BIT_EN
    ovf_d    = 1'b0;
    result_d = sat8(result_d, ovf_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef SATURATE_8BIT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            bcd_q   <= bus.bcd_in;
            neg_q   <= bus.negative;
            err_q   <= 1'b0;
`ifdef SATURATE_8BIT_EN
            ovf_q   <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bcd_invalid(bcd_q)) begin
            err_q    <= 1'b1;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            sr_q    <= {bcd_q, {BIN_W{1'b0}}};
            cnt_q   <= CNT_W'(BIN_W);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_NEGATE;
        end
        S_NEGATE: begin
          result_q <= result_d;
`ifdef SATURATE_8BIT_EN
          ovf_q    <= ovf_d;
`endif
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
`ifdef SATURATE_8BIT_EN
  assign bus.ovf    = ovf_q;
`else
  assign bus.ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_signed_bin.sv
// Directed and randomized bench for bcd_to_signed_bin against an arithmetic reference model.
module tb_bcd_to_signed_bin;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_to_signed_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_signed_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, signed, optionally clamped, wrapped to BIN_W+1 bits.
  task automatic model(input logic [11:0] b, input logic n,
                       output logic [10:0] r, output logic e, output logic o);
    int val;
    int s;
    logic [3:0] d;
    e = 1'b0; o = 1'b0; val = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      val = val * 10 + int'(d);
    end
    s = n ? -val : val;
`ifdef SATURATE_8BIT_EN
    if (s > 127) begin s = 127; o = 1'b1; end
    else if (s < -128) begin s = -128; o = 1'b1; end
`endif
    if (e) begin s = 0; o = 1'b0; end
    r = s[10:0];
  endtask

  task automatic run_conv(input logic [11:0] b, input logic n, input string tag);
    logic [10:0] er;
    logic ee, eo, seen, busy_ok;
    int exp_cyc, c;
    model(b, n, er, ee, eo);
    exp_cyc = ee ? 2 : BIN_W + 3;
    @(negedge clk);
    bus.bcd_in = b; bus.negative = n; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bcd_in = 12'($urandom);
    bus.negative = 1'($urandom);
    c = 1; seen = 1'b0; busy_ok = 1'b1;
    while (c <= 40 && !seen) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk); #1;
        c++;
      end
    end
    chk({tag, "_latency"}, seen ? c : 32'hFFFF_FFFF, exp_cyc);
    chk({tag, "_result"}, 32'($unsigned(bus.result)), 32'(er));
    chk({tag, "_err"}, 32'(bus.err), 32'(ee));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_result_hold"}, 32'($unsigned(bus.result)), 32'(er));
  endtask

  logic [10:0] er;
  logic ee, eo;
  logic [11:0] rb;
  logic rn;
  int dones, first, d1, d2;
  logic [10:0] r_first;
  logic saw_done;

  initial begin
    bus.start = 1'b0; bus.negative = 1'b0; bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({bus.busy, bus.done, $unsigned(bus.result), bus.err, bus.ovf}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_conv(12'h127, 1'b0, "d127");
    run_conv(12'h005, 1'b1, "neg5");
    run_conv(12'h000, 1'b1, "negzero");
    run_conv(12'h999, 1'b0, "d999");
    run_conv(12'h200, 1'b1, "neg200");
    run_conv(12'h1A3, 1'b0, "bad_digit");
    run_conv(12'h127, 1'b0, "err_clear");
    run_conv(12'hF00, 1'b1, "bad_top");

    // Second start while busy must be ignored.
    model(12'h314, 1'b1, er, ee, eo);
    @(negedge clk);
    bus.bcd_in = 12'h314; bus.negative = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; first = -1; r_first = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin bus.start = 1'b1; bus.bcd_in = 12'h999; bus.negative = 1'b0; end
      if (c == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin first = c; r_first = 11'($unsigned(bus.result)); end
      end
      @(posedge clk); #1;
    end
    chk("ignore_done_count", dones, 1);
    chk("ignore_latency", first, BIN_W + 3);
    chk("ignore_result", 32'(r_first), 32'(er));

    // Start held high: DONE cycle does not accept, the following IDLE cycle does.
    @(negedge clk);
    bus.bcd_in = 12'h042; bus.negative = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 40 && d2 < 0; c++) begin
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else begin d2 = c; bus.start = 1'b0; end
      end
      if (d2 < 0) begin @(posedge clk); #1; end
    end
    bus.start = 1'b0;
    chk("held_first_done", d1, BIN_W + 3);
    chk("held_second_done", d2, 2 * (BIN_W + 3) + 1);
    chk("held_result", 32'($unsigned(bus.result)), 32'h2A);
    repeat (2) begin @(posedge clk); #1; end
    chk("held_released_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.bcd_in = 12'h500; bus.negative = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({bus.busy, bus.done, $unsigned(bus.result), bus.err, bus.ovf}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.done === 1'b1) saw_done = 1'b1; end
    chk("midreset_no_done", 32'(saw_done), 32'd0);
    run_conv(12'h127, 1'b0, "after_reset");

    for (int k = 0; k < 40; k++) begin
      rb = 12'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < DIGITS; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      rn = 1'($urandom_range(0, 1));
      run_conv(rb, rn, $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
